// File: rtl/rx_buf_ctrl.sv
// Receive-side packet buffer: captures fixed-length HEADER-led packets from the
// RX word stream into a FIFO and flags the DRAM writer once a whole packet is held.
module rx_buf_ctrl #(
    parameter int          PKT_LEN = 128,
    parameter int          DEPTH   = 512,
    parameter logic [15:0] HEADER  = 16'hDEAD,
    parameter logic [15:0] TRAILER = 16'hBEEF
) (
    input  logic        rx_std_clkout,
    input  logic        rst_n,
    input  logic [1:0]  rx_syncstatus,
    input  logic [1:0]  rx_datak,
    input  logic [15:0] RX_data,
    input  logic        DRAM_RD_clk,
    input  logic        DRAM_RD_req,
    output logic        RX_Buffer_empty,
    output logic [15:0] Buffer_RD_Data,
    output logic        Buffer_Data_Ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(PKT_LEN);
    localparam int PW = $clog2(DEPTH / PKT_LEN + 1);

    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PKT_WORDS = (AW + 1)'(PKT_LEN);
    localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic          valid, is_hdr, has_space;
    logic          wr_en, wr_last, rd_en, rd_last;
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [PW-1:0] pkt_cnt;

    // DRAM_RD_clk shares the rx_std_clkout source and TRAILER is informational;
    // neither feeds any logic.
    logic unused_ok;
    assign unused_ok = DRAM_RD_clk & (&TRAILER);

    assign valid     = (rx_syncstatus == 2'b11) && (rx_datak == 2'b00);
    assign is_hdr    = (RX_data == HEADER);
    assign has_space = (DEPTH_CNT - count) >= PKT_WORDS;
    assign rd_en     = DRAM_RD_req && (count != '0);
    assign rd_last   = rd_en && mem[rd_ptr][16];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:          if (valid && is_hdr)         state_nxt = has_space ? PAYLOAD : DROP;
            PAYLOAD, DROP: if (valid && idx == LAST_IDX) state_nxt = IDLE;
            default:                                    state_nxt = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        unique case (state)
            IDLE:    wr_en = valid && is_hdr && has_space;
            PAYLOAD: begin
                wr_en   = valid;
                wr_last = valid && (idx == LAST_IDX);
            end
            default: ;
        endcase
    end

    // Word index within the packet; shared by capture and drop counting.
    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n)                 idx <= '0;
        else if (state == IDLE) begin
            if (valid && is_hdr)    idx <= IW'(1);
        end else if (valid)         idx <= idx + IW'(1);
    end

    // NOTE: the storage array has no reset; occupancy and pointers define which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge rx_std_clkout) begin
        if (wr_en) mem[wr_ptr] <= {wr_last, RX_data};
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pkt_cnt        <= '0;
            Buffer_RD_Data <= 16'h0000;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                rd_ptr         <= rd_ptr + AW'(1);
                Buffer_RD_Data <= mem[rd_ptr][15:0];
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            unique case ({wr_last, rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: ;
            endcase
        end
    end

    assign RX_Buffer_empty   = (count == '0);
    assign Buffer_Data_Ready = (pkt_cnt != '0);

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Self-checking bench for rx_buf_ctrl: reset/table vectors, directed corner
// sequences and randomized traffic against a queue-based packet model.
module tb_rx_buf_ctrl;
    localparam int PKT_LEN = 128;
    localparam int DEPTH   = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rx_syncstatus;
    logic [1:0]  rx_datak;
    logic [15:0] RX_data;
    logic        DRAM_RD_clk;
    logic        DRAM_RD_req;
    logic        RX_Buffer_empty;
    logic [15:0] Buffer_RD_Data;
    logic        Buffer_Data_Ready;

    always #5 clk = ~clk;
    assign DRAM_RD_clk = clk;

    rx_buf_ctrl dut (
        .rx_std_clkout    (clk),
        .rst_n            (rst_n),
        .rx_syncstatus    (rx_syncstatus),
        .rx_datak         (rx_datak),
        .RX_data          (RX_data),
        .DRAM_RD_clk      (DRAM_RD_clk),
        .DRAM_RD_req      (DRAM_RD_req),
        .RX_Buffer_empty  (RX_Buffer_empty),
        .Buffer_RD_Data   (Buffer_RD_Data),
        .Buffer_Data_Ready(Buffer_Data_Ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    int rd_mode  = 0;   // 0 none, 1 follow Buffer_Data_Ready, 2 random, 3 always

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of {last, word}, plus packet-level bookkeeping.
    logic [16:0] mq[$];
    int          m_pkts;
    int          m_remain;
    bit          m_accept;
    logic [15:0] m_rd;

    task automatic model_reset();
        mq.delete();
        m_pkts   = 0;
        m_remain = 0;
        m_accept = 0;
        m_rd     = 16'h0000;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] d, input logic req);
        int          space;
        logic [16:0] w;
        logic        last;
        space = DEPTH - mq.size();
        if (req && mq.size() != 0) begin
            w    = mq.pop_front();
            m_rd = w[15:0];
            if (w[16]) m_pkts--;
        end
        if (v) begin
            if (m_remain == 0) begin
                if (d == 16'hDEAD) begin
                    m_remain = PKT_LEN - 1;
                    m_accept = (space >= PKT_LEN);
                    if (m_accept) mq.push_back({1'b0, d});
                end
            end else begin
                last = (m_remain == 1);
                if (m_accept) begin
                    mq.push_back({last, d});
                    if (last) m_pkts++;
                end
                m_remain--;
            end
        end
    endtask

    task automatic step(input logic [1:0] ss, input logic [1:0] dk, input logic [15:0] d,
                        input logic req, input string tag);
        rx_syncstatus = ss;
        rx_datak      = dk;
        RX_data       = d;
        DRAM_RD_req   = req;
        if (req && !RX_Buffer_empty) n_reads++;
        @(posedge clk);
        model_edge(ss == 2'b11 && dk == 2'b00, d, req);
        #1;
        check(tag, {14'd0, Buffer_RD_Data, RX_Buffer_empty, Buffer_Data_Ready},
                   {14'd0, m_rd, mq.size() == 0, m_pkts != 0});
    endtask

    function automatic logic get_req();
        case (rd_mode)
            1:       return Buffer_Data_Ready;
            2:       return 1'($urandom_range(0, 1));
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_invalid(input string tag);
        logic [1:0] ss, dk;
        if ($urandom_range(0, 1) == 1) begin
            ss = 2'($urandom_range(0, 2));
            dk = 2'($urandom_range(0, 3));
        end else begin
            ss = 2'b11;
            dk = 2'($urandom_range(1, 3));
        end
        step(ss, dk, 16'($urandom), get_req(), tag);
    endtask

    logic [15:0] pkt [PKT_LEN];

    task automatic build_pkt(input logic [15:0] ts, input bit seq);
        pkt[0] = 16'hDEAD;
        pkt[1] = ts;
        for (int i = 2; i < PKT_LEN - 1; i++)
            pkt[i] = seq ? 16'(16'h1000 + i - 2) : 16'($urandom);
        pkt[PKT_LEN-1] = 16'hBEEF;
    endtask

    task automatic send_range(input int lo, input int hi, input int inv_pct, input string tag);
        for (int i = lo; i <= hi; i++) begin
            while ($urandom_range(0, 99) < inv_pct) send_invalid({tag, "_gap"});
            step(2'b11, 2'b00, pkt[i], get_req(), tag);
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (!RX_Buffer_empty && n < 2 * DEPTH) begin
            step(2'b00, 2'b00, 16'hFFFF, 1'b1, "drain");
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("reset_rd_data", 32'(Buffer_RD_Data), 32'h0000);
        check("reset_empty",   32'(RX_Buffer_empty), 32'd1);
        check("reset_ready",   32'(Buffer_Data_Ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  ss;
        logic [1:0]  dk;
        logic [15:0] d;
        logic        req;
        logic [15:0] rd;
        logic        empty;
        logic        ready;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n;

        vecs[0]  = '{2'b11, 2'b00, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{2'b11, 2'b00, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{2'b11, 2'b01, 16'hDEAD, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 2'b00, 16'hDEAD, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{2'b11, 2'b00, 16'hBEEF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{2'b11, 2'b00, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 2'b00, 16'h0005, 1'b1, 16'hDEAD, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 2'b00, 16'h1000, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[8]  = '{2'b01, 2'b00, 16'h1001, 1'b1, 16'h1000, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 2'b00, 16'h1002, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 2'b11, 16'hFFFF, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n         = 1'b0;
        rx_syncstatus = 2'b00;
        rx_datak      = 2'b00;
        RX_data       = 16'h0000;
        DRAM_RD_req   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Short hand-computed vectors from reset: filtering, first write, read latency.
        for (int i = 0; i < 11; i++) begin
            rx_syncstatus = vecs[i].ss;
            rx_datak      = vecs[i].dk;
            RX_data       = vecs[i].d;
            DRAM_RD_req   = vecs[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {13'd0, Buffer_RD_Data, RX_Buffer_empty, Buffer_Data_Ready, 1'b0},
                  {13'd0, vecs[i].rd, vecs[i].empty, vecs[i].ready, 1'b0});
        end
        do_reset();

        // One packet, idles first, no reads.
        rd_mode = 0;
        repeat (4) step(2'b11, 2'b00, 16'hFFFF, 1'b0, "idle");
        build_pkt(16'h0005, 1'b1);
        send_range(0, PKT_LEN - 1, 0, "pkt1");
        check("pkt1_ready", 32'(Buffer_Data_Ready), 32'd1);
        drain(n);
        check("pkt1_occupancy", n, PKT_LEN);

        // 16 back-to-back packets with a reader that follows Buffer_Data_Ready.
        rd_mode = 1;
        n_reads = 0;
        for (int p = 0; p < 16; p++) begin
            build_pkt(16'(5 + p), 1'b0);
            send_range(0, PKT_LEN - 1, 0, "b2b");
        end
        n = 0;
        while (!RX_Buffer_empty && n < 1000) begin
            step(2'b00, 2'b00, 16'hFFFF, get_req(), "b2b_tail");
            n++;
        end
        check("b2b_words_read", n_reads, 16 * PKT_LEN);
        check("b2b_empty", 32'(RX_Buffer_empty), 32'd1);

        // Three unsynced words mid-packet are skipped.
        rd_mode = 0;
        build_pkt(16'h0042, 1'b0);
        send_range(0, 49, 0, "sync");
        repeat (3) step(2'b01, 2'b00, 16'($urandom), 1'b0, "sync_skip");
        send_range(50, PKT_LEN - 2, 0, "sync");
        check("sync_ready_early", 32'(Buffer_Data_Ready), 32'd0);
        send_range(PKT_LEN - 1, PKT_LEN - 1, 0, "sync");
        check("sync_ready_done", 32'(Buffer_Data_Ready), 32'd1);
        drain(n);
        check("sync_len", n, PKT_LEN);

        // Overflow: four packets fill the buffer, the fifth is dropped.
        for (int p = 0; p < 5; p++) begin
            build_pkt(16'(16'h0100 + p), 1'b0);
            send_range(0, PKT_LEN - 1, 0, "ovf");
        end
        check("ovf_ready", 32'(Buffer_Data_Ready), 32'd1);
        drain(n);
        check("ovf_occupancy", n, DEPTH);

        // Read requests on an empty FIFO are ignored.
        rd_mode = 3;
        repeat (6) step(2'b00, 2'b00, 16'hFFFF, get_req(), "empty_req");
        check("empty_req_empty", 32'(RX_Buffer_empty), 32'd1);

        // Reset at payload word 60, then a clean packet.
        rd_mode = 0;
        build_pkt(16'h0077, 1'b0);
        send_range(0, 60, 0, "mid_rst");
        do_reset();
        build_pkt(16'h0078, 1'b1);
        send_range(0, PKT_LEN - 1, 0, "post_rst");
        check("post_rst_ready", 32'(Buffer_Data_Ready), 32'd1);
        drain(n);
        check("post_rst_len", n, PKT_LEN);

        // Randomized traffic: gaps, invalid words, varied readers, occasional drops.
        for (int p = 0; p < 20; p++) begin
            rd_mode = $urandom_range(0, 3);
            repeat ($urandom_range(0, 5)) step(2'b11, 2'b00, 16'hFFFF, get_req(), "rnd_idle");
            build_pkt(16'($urandom), 1'b0);
            send_range(0, PKT_LEN - 1, 15, "rnd");
        end
        drain(n);
        check("rnd_final_empty", 32'(RX_Buffer_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
